// File: rtl/data_memory_port_if.sv
// rtl/data_memory_port_if.sv - request, completion and byte-wide RAM bus signals of the data memory port
interface data_memory_port_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  clearIn;
  logic [1:0]            accessType;
  logic                  readWriteIn;
  logic [ADDR_WIDTH-1:0] dataAddr;
  logic [31:0]           dataWrite;
  logic                  dataValid;
  logic [31:0]           dataOut;
  logic                  dataWriteSuc;
  logic                  busy;
  logic                  memRequest;
  logic                  memGranted;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memWrite;
  logic [7:0]            memOut;
  logic [7:0]            memIn;
  logic                  ioBufferFull;

  modport slave (
    input  clearIn, accessType, readWriteIn, dataAddr, dataWrite,
    input  memGranted, memIn, ioBufferFull,
    output dataValid, dataOut, dataWriteSuc, busy,
    output memRequest, memAddr, memWrite, memOut
  );

  modport master (
    output clearIn, accessType, readWriteIn, dataAddr, dataWrite,
    output memGranted, memIn, ioBufferFull,
    input  dataValid, dataOut, dataWriteSuc, busy,
    input  memRequest, memAddr, memWrite, memOut
  );
endinterface

// File: rtl/data_memory_port.sv
// rtl/data_memory_port.sv - serializes byte/half/word loads and stores onto a shared byte-wide RAM bus
module data_memory_port #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clockIn,
  input logic               resetIn,
  data_memory_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_e;

  state_e                state_q;
  logic                  is_read_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            last_q;
  logic [1:0]            k_q;
  logic [23:0]           rdata_q;
  logic                  data_valid_q;
  logic                  write_suc_q;
  logic                  mem_request_q;
  logic                  mem_write_q;
  logic                  busy_q;
  logic [31:0]           data_out_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_out_q;

  logic [1:0]            nxt_k;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [7:0]            cur_byte;
  logic [7:0]            nxt_byte;
  logic                  stall_cur;
  logic                  stall_nxt;
  logic [31:0]           read_word;
  logic [1:0]            req_last;

  assign nxt_k     = k_q + 2'd1;
  assign cur_addr  = addr_q + ADDR_WIDTH'(k_q);
  assign nxt_addr  = addr_q + ADDR_WIDTH'(nxt_k);
  assign cur_byte  = wdata_q[{k_q, 3'b000} +: 8];
  assign nxt_byte  = wdata_q[{nxt_k, 3'b000} +: 8];
  assign stall_cur = (cur_addr[17:16] == 2'b11) && bus.ioBufferFull;
  assign stall_nxt = (nxt_addr[17:16] == 2'b11) && bus.ioBufferFull;

  // Merge the byte arriving now into lane k; lanes above k stay zero.
  always_comb begin
    read_word = 32'h0;
    case (k_q)
      2'd0:    read_word = {24'h0, bus.memIn};
      2'd1:    read_word = {16'h0, bus.memIn, rdata_q[7:0]};
      2'd2:    read_word = {8'h0, bus.memIn, rdata_q[15:0]};
      default: read_word = {bus.memIn, rdata_q};
    endcase
  end

  always_comb begin
    req_last = 2'd0;
    case (bus.accessType)
      2'b10:   req_last = 2'd1;
      2'b11:   req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q       <= IDLE;
      is_read_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_q        <= '0;
      k_q           <= '0;
      rdata_q       <= '0;
      data_valid_q  <= 1'b0;
      write_suc_q   <= 1'b0;
      mem_request_q <= 1'b0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      data_out_q    <= '0;
      mem_addr_q    <= '0;
      mem_out_q     <= '0;
    end else begin
      data_valid_q <= 1'b0;
      write_suc_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A flush squashes a load arriving with it, but a store is already committed.
          if (bus.accessType != 2'b00 && !(bus.clearIn && bus.readWriteIn)) begin
            state_q       <= REQ;
            busy_q        <= 1'b1;
            mem_request_q <= 1'b1;
            is_read_q     <= bus.readWriteIn;
            addr_q        <= bus.dataAddr;
            wdata_q       <= bus.dataWrite;
            last_q        <= req_last;
            k_q           <= 2'd0;
            rdata_q       <= '0;
          end
        end
        REQ: begin
          if (is_read_q && bus.clearIn) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            mem_request_q <= 1'b0;
          end else if (bus.memGranted) begin
            state_q <= ACCESS;
            if (is_read_q) begin
              mem_addr_q <= cur_addr;
            end else if (!stall_cur) begin
              mem_addr_q  <= cur_addr;
              mem_out_q   <= cur_byte;
              mem_write_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (is_read_q) begin
            if (bus.clearIn) begin
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              mem_request_q <= 1'b0;
            end else begin
              rdata_q <= read_word[23:0];
              if (k_q == last_q) begin
                data_out_q    <= read_word;
                data_valid_q  <= 1'b1;
                state_q       <= IDLE;
                busy_q        <= 1'b0;
                mem_request_q <= 1'b0;
              end else begin
                k_q        <= nxt_k;
                mem_addr_q <= nxt_addr;
              end
            end
          end else if (mem_write_q) begin
            if (k_q == last_q) begin
              mem_write_q   <= 1'b0;
              write_suc_q   <= 1'b1;
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              mem_request_q <= 1'b0;
            end else begin
              k_q         <= nxt_k;
              mem_write_q <= !stall_nxt;
              if (!stall_nxt) begin
                mem_addr_q <= nxt_addr;
                mem_out_q  <= nxt_byte;
              end
            end
          end else if (!stall_cur) begin
            // Byte k was held back by a full I/O buffer; issue it now.
            mem_write_q <= 1'b1;
            mem_addr_q  <= cur_addr;
            mem_out_q   <= cur_byte;
          end
        end
        default: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          mem_request_q <= 1'b0;
          mem_write_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataValid    = data_valid_q;
  assign bus.dataOut      = data_out_q;
  assign bus.dataWriteSuc = write_suc_q;
  assign bus.busy         = busy_q;
  assign bus.memRequest   = mem_request_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.memWrite     = mem_write_q;
  assign bus.memOut       = mem_out_q;
endmodule

// File: tb/tb_data_memory_port.sv
// tb/tb_data_memory_port.sv - directed bench with a transaction-level reference model and byte RAM
module tb_data_memory_port;
  logic clk;
  logic rst;

  data_memory_port_if #(.ADDR_WIDTH(32)) bus ();

  data_memory_port #(.ADDR_WIDTH(32)) dut (
    .clockIn (clk),
    .resetIn (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int          checks;
  int          failures;
  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_ram [logic [31:0]];
  wr_t         exp_wr  [$];
  logic [31:0] exp_rd  [$];
  int          exp_wc;
  logic        req_h   [64];
  logic        busy_h  [64];
  logic        wr_h    [64];
  logic [31:0] addr_h  [64];
  logic [31:0] last_data;
  int          lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] ram_at(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_at(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_ram[a] = d;
  endtask

  // Reference: what a request must eventually do, independent of cycle timing.
  task automatic model_push(input logic rd, input logic [1:0] t, input logic [31:0] a,
                            input logic [31:0] d, input int keep, input logic done);
    int          n;
    logic [31:0] v;
    logic [31:0] ai;
    n = (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
    if (rd) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
        ai = a + i;
        v  = v | (32'(ref_at(ai)) << (8 * i));
      end
      if (done) exp_rd.push_back(v);
    end else begin
      for (int i = 0; i < keep; i++) begin
        ai          = a + i;
        ref_ram[ai] = d[8*i +: 8];
        exp_wr.push_back('{a: ai, d: d[8*i +: 8]});
      end
      if (done) exp_wc++;
    end
  endtask

  // RAM responder plus the per-cycle compare against the reference model.
  always @(negedge clk) begin
    if (bus.memWrite) begin
      ram[bus.memAddr] = bus.memOut;
      if (exp_wr.size() == 0) begin
        chk("unexpected_memWrite", 32'(bus.memWrite), 32'h0);
      end else begin
        chk("memWrite_addr", bus.memAddr, exp_wr[0].a);
        chk("memWrite_data", 32'(bus.memOut), 32'(exp_wr[0].d));
        void'(exp_wr.pop_front());
      end
    end
    bus.memIn = ram_at(bus.memAddr);
    if (bus.dataValid) begin
      if (exp_rd.size() == 0) chk("unexpected_dataValid", 32'(bus.dataValid), 32'h0);
      else chk("read_data", bus.dataOut, exp_rd.pop_front());
    end
    if (bus.dataWriteSuc) begin
      if (exp_wc == 0) chk("unexpected_dataWriteSuc", 32'(bus.dataWriteSuc), 32'h0);
      else exp_wc--;
    end
  end

  task automatic issue(input logic [1:0] t, input logic rd, input logic [31:0] a, input logic [31:0] d,
                       input logic clr, input logic exp_acc, input int keep, input logic done);
    bus.accessType  = t;
    bus.readWriteIn = rd;
    bus.dataAddr    = a;
    bus.dataWrite   = d;
    bus.clearIn     = clr;
    if (exp_acc) model_push(rd, t, a, d, keep, done);
    @(posedge clk);
    #1;
    bus.accessType = 2'b00;
    bus.clearIn    = 1'b0;
    chk("accept_busy", 32'(bus.busy), 32'(exp_acc));
  endtask

  task automatic run(input int gd, input int io, input int clr_at, input int rst_at,
                     input int maxc, output int l);
    bus.memGranted   = (gd == 0);
    bus.ioBufferFull = (io > 0);
    l = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk);
      #1;
      req_h[c]  = bus.memRequest;
      busy_h[c] = bus.busy;
      wr_h[c]   = bus.memWrite;
      addr_h[c] = bus.memAddr;
      if (bus.dataValid || bus.dataWriteSuc) begin
        l         = c;
        last_data = bus.dataOut;
        break;
      end
      if (c == gd) bus.memGranted = 1'b1;
      if (c == io) bus.ioBufferFull = 1'b0;
      bus.clearIn = (c == clr_at);
      rst         = (c == rst_at);
    end
    bus.clearIn      = 1'b0;
    rst              = 1'b0;
    bus.memGranted   = 1'b1;
    bus.ioBufferFull = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0; exp_wc = 0;
    rst = 1'b1;
    bus.clearIn = 1'b0; bus.accessType = 2'b00; bus.readWriteIn = 1'b0;
    bus.dataAddr = '0; bus.dataWrite = '0; bus.memGranted = 1'b1;
    bus.ioBufferFull = 1'b0; bus.memIn = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_memRequest", 32'(bus.memRequest), 32'h0);
    chk("rst_memWrite", 32'(bus.memWrite), 32'h0);
    chk("rst_pulses", 32'(bus.dataValid | bus.dataWriteSuc), 32'h0);
    chk("rst_dataOut", bus.dataOut, 32'h0);
    chk("rst_memAddr", bus.memAddr, 32'h0);
    chk("rst_memOut", 32'(bus.memOut), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h300, 8'h5A);

    // Word read
    issue(2'b11, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1, 0, 1'b1);
    run(0, 0, 0, 0, 20, lat);
    chk("word_read_latency", 32'(lat), 32'd5);
    chk("word_read_data", last_data, 32'h12345678);
    for (int i = 1; i <= 4; i++) begin
      chk("word_read_memAddr", addr_h[i], 32'h100 + 32'(i - 1));
      chk("word_read_memRequest", 32'(req_h[i]), 32'h1);
    end
    @(posedge clk);
    #1;
    chk("word_read_pulse_width", 32'(bus.dataValid), 32'h0);

    // Half write, byte read issued in the dataWriteSuc cycle
    issue(2'b10, 1'b0, 32'h202, 32'h0000BEEF, 1'b0, 1'b1, 2, 1'b1);
    run(0, 0, 0, 0, 20, lat);
    chk("half_write_latency", 32'(lat), 32'd3);
    issue(2'b01, 1'b1, 32'h203, 32'h0, 1'b0, 1'b1, 0, 1'b1);
    run(0, 0, 0, 0, 20, lat);
    chk("byte_read_latency", 32'(lat), 32'd2);
    chk("byte_read_data", last_data, 32'h000000BE);
    chk("ram_202", 32'(ram_at(32'h202)), 32'hEF);
    chk("ram_203", 32'(ram_at(32'h203)), 32'hBE);

    // Grant withheld for 3 cycles
    issue(2'b01, 1'b1, 32'h300, 32'h0, 1'b0, 1'b1, 0, 1'b1);
    run(3, 0, 0, 0, 20, lat);
    chk("grant_delay_latency", 32'(lat), 32'd5);
    chk("grant_delay_data", last_data, 32'h0000005A);
    for (int i = 1; i <= 3; i++) begin
      chk("grant_delay_memRequest", 32'(req_h[i]), 32'h1);
      chk("grant_delay_addr_not_driven", 32'(addr_h[i] == 32'h300), 32'h0);
    end

    // I/O buffer full for 2 cycles
    issue(2'b01, 1'b0, 32'h30000, 32'h00000077, 1'b0, 1'b1, 1, 1'b1);
    run(0, 2, 0, 0, 20, lat);
    chk("io_stall_latency", 32'(lat), 32'd4);
    chk("io_stall_wr1", 32'(wr_h[1]), 32'h0);
    chk("io_stall_wr2", 32'(wr_h[2]), 32'h0);
    chk("io_stall_wr3", 32'(wr_h[3]), 32'h1);

    // clearIn in 2nd byte cycle of a word read
    issue(2'b11, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1, 0, 1'b0);
    run(0, 0, 2, 0, 8, lat);
    chk("clear_read_no_pulse", 32'(lat), 32'hFFFFFFFF);
    chk("clear_read_memRequest", 32'(req_h[3]), 32'h0);
    chk("clear_read_busy", 32'(busy_h[3]), 32'h0);

    // clearIn in 2nd byte cycle of a word write is ignored
    issue(2'b11, 1'b0, 32'h400, 32'h11223344, 1'b0, 1'b1, 4, 1'b1);
    run(0, 0, 2, 0, 20, lat);
    chk("clear_write_latency", 32'(lat), 32'd5);
    chk("clear_write_ram403", 32'(ram_at(32'h403)), 32'h11);

    // Request arriving with clearIn: load dropped, store taken
    issue(2'b01, 1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    issue(2'b01, 1'b0, 32'h600, 32'h00000099, 1'b1, 1'b1, 1, 1'b1);
    run(0, 0, 0, 0, 20, lat);
    chk("clear_same_cycle_write_latency", 32'(lat), 32'd2);

    // Address wrap-around
    issue(2'b11, 1'b0, 32'hFFFFFFFE, 32'hAABBCCDD, 1'b0, 1'b1, 4, 1'b1);
    run(0, 0, 0, 0, 20, lat);
    chk("wrap_latency", 32'(lat), 32'd5);
    chk("wrap_fffffffe", 32'(ram_at(32'hFFFFFFFE)), 32'hDD);
    chk("wrap_ffffffff", 32'(ram_at(32'hFFFFFFFF)), 32'hCC);
    chk("wrap_0", 32'(ram_at(32'h0)), 32'hBB);
    chk("wrap_1", 32'(ram_at(32'h1)), 32'hAA);

    // Reset during byte 1 of a word write
    issue(2'b11, 1'b0, 32'h500, 32'h01020304, 1'b0, 1'b1, 2, 1'b0);
    run(0, 0, 0, 2, 8, lat);
    chk("reset_no_pulse", 32'(lat), 32'hFFFFFFFF);
    chk("reset_byte1_driven", 32'(wr_h[2]), 32'h1);
    chk("reset_memWrite", 32'(wr_h[3]), 32'h0);
    chk("reset_memRequest", 32'(req_h[3]), 32'h0);
    chk("reset_busy", 32'(busy_h[3]), 32'h0);
    chk("reset_ram501", 32'(ram_at(32'h501)), 32'h03);
    chk("reset_ram502", 32'(ram_at(32'h502)), 32'h00);

    repeat (2) @(posedge clk);
    #1;
    chk("left_expected_writes", 32'(exp_wr.size()), 32'h0);
    chk("left_expected_reads", 32'(exp_rd.size()), 32'h0);
    chk("left_expected_write_done", 32'(exp_wc), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
